// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared constants, FSM states and owner encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int   ADDR_BUS     = 32;
  localparam int   DATA_BUS     = 32;
  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_grant.sv
// ============================================================================
// arb_grant : combinational winner select between IF and MEM requesters.
// ARB_FAIR_EN adds the fairness-flag input that hands contention to IF.  Rev 1.0
// ============================================================================
`default_nettype none

module arb_grant
  import mem_port_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic mem_req,
`ifdef ARB_FAIR_EN
  input  logic fair_flag,
`endif
  output logic grant_vld,
  output logic grant_own
);

  always_comb begin
    grant_vld = if_req | mem_req;
`ifdef ARB_FAIR_EN
    // MEM wins unless it won the previous contended round.
    grant_own = (mem_req && !(if_req && fair_flag)) ? OWN_MEM : OWN_IF;
`else
    grant_own = mem_req ? OWN_MEM : OWN_IF;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one fixed-latency sync RAM between IF and MEM.
// Optional macro ARB_FAIR_EN alternates grants under contention.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = ADDR_BUS,
  parameter int DATA_W  = DATA_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_req
);

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [3:0]        ram_sel_q, ram_sel_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
  logic              grant_vld, grant_own;
`ifdef ARB_FAIR_EN
  logic              fair_q, fair_d;
`endif

  arb_grant u_arb_grant (
    .if_req    (if_req),
    .mem_req   (mem_req),
`ifdef ARB_FAIR_EN
    .fair_flag (fair_q),
`endif
    .grant_vld (grant_vld),
    .grant_own (grant_own)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ram_en_d    = CHIP_DISABLE;
    ram_we_d    = 1'b0;
    ram_sel_d   = ram_sel_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
`ifdef ARB_FAIR_EN
    fair_d      = fair_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (grant_vld) begin
          state_d  = ARB_ACCESS;
          owner_d  = arb_owner_e'(grant_own);
          ram_en_d = CHIP_ENABLE;
          if (grant_own == OWN_MEM) begin
            ram_we_d    = mem_we;
            ram_sel_d   = mem_sel;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
          end else begin
            ram_sel_d   = 4'hF;
            ram_addr_d  = if_addr;
          end
`ifdef ARB_FAIR_EN
          if (grant_own == OWN_MEM && if_req) fair_d = 1'b1;
          else if (grant_own == OWN_IF && mem_req) fair_d = 1'b0;
`endif
        end
      end
      ARB_ACCESS: begin
        state_d = ARB_WAIT;
        cnt_d   = CNT_LOAD;
      end
      ARB_WAIT: begin
        // Last WAIT cycle: RAM output is valid now, capture into the owner.
        if (cnt_q == '0) begin
          state_d = ARB_RESP;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = ram_rdata;
            mem_ready_d = 1'b1;
          end else begin
            if_rdata_d  = ram_rdata;
            if_ready_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      ram_en_q    <= CHIP_DISABLE;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= DATA_W'(ZERO_WORD);
      if_rdata_q  <= DATA_W'(ZERO_WORD);
      mem_rdata_q <= DATA_W'(ZERO_WORD);
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
`ifdef ARB_FAIR_EN
      fair_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_sel_q   <= ram_sel_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
`ifdef ARB_FAIR_EN
      fair_q      <= fair_d;
`endif
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_sel   = ram_sel_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign stall_req = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : two arbiters (LATENCY 1 and 4) on shared stimulus,
// checked every cycle against a transaction-level model.  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, mem_req, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] if_addr, mem_addr, mem_wdata;

  logic [31:0] ram_rdata_i [2];
  logic [31:0] if_rdata_o [2], mem_rdata_o [2], ram_addr_o [2], ram_wdata_o [2];
  logic        if_ready_o [2], mem_ready_o [2], ram_en_o [2], ram_we_o [2], stall_o [2];
  logic [3:0]  ram_sel_o [2];

  int tests, fails, cyc;

  mem_port_arbiter #(.LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[0]), .if_ready(if_ready_o[0]),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_o[0]), .mem_ready(mem_ready_o[0]),
    .ram_en(ram_en_o[0]), .ram_we(ram_we_o[0]), .ram_sel(ram_sel_o[0]), .ram_addr(ram_addr_o[0]),
    .ram_wdata(ram_wdata_o[0]), .ram_rdata(ram_rdata_i[0]), .stall_req(stall_o[0])
  );

  mem_port_arbiter #(.LATENCY(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[1]), .if_ready(if_ready_o[1]),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_o[1]), .mem_ready(mem_ready_o[1]),
    .ram_en(ram_en_o[1]), .ram_we(ram_we_o[1]), .ram_sel(ram_sel_o[1]), .ram_addr(ram_addr_o[1]),
    .ram_wdata(ram_wdata_o[1]), .ram_rdata(ram_rdata_i[1]), .stall_req(stall_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: each access is a start cycle plus fixed offsets.
  bit          m_busy [2], m_own_mem [2], m_we [2], m_mem_known [2], m_fair [2];
  int          m_start [2];
  logic [31:0] m_addr [2], m_wdata [2], m_rd [2], m_if_rd [2], m_mem_rd [2];
  logic [3:0]  m_sel [2];
  logic [31:0] mem_m [2][256];
  logic [31:0] ram_mem [2][256];

  task automatic model_step(int i);
    bit pick_mem;
    if (rst) begin
      m_busy[i] = 0; m_we[i] = 0; m_sel[i] = 4'h0; m_addr[i] = '0; m_wdata[i] = '0;
      m_if_rd[i] = '0; m_mem_rd[i] = '0; m_mem_known[i] = 1; m_fair[i] = 0;
    end else if (m_busy[i]) begin
      if (cyc == m_start[i] + lat(i) + 1) begin
        if (m_own_mem[i]) begin
          m_mem_rd[i] = m_rd[i];
          m_mem_known[i] = !m_we[i];
        end else begin
          m_if_rd[i] = m_rd[i];
        end
      end
      if (cyc == m_start[i] + lat(i) + 2) m_busy[i] = 0;
    end else if (if_req || mem_req) begin
      pick_mem = mem_req;
`ifdef ARB_FAIR_EN
      if (mem_req && if_req && m_fair[i]) pick_mem = 0;
      if (pick_mem && if_req) m_fair[i] = 1;
      else if (!pick_mem && mem_req) m_fair[i] = 0;
`endif
      m_busy[i] = 1; m_start[i] = cyc; m_own_mem[i] = pick_mem;
      if (pick_mem) begin
        m_addr[i] = mem_addr; m_we[i] = mem_we; m_sel[i] = mem_sel; m_wdata[i] = mem_wdata;
      end else begin
        m_addr[i] = if_addr; m_we[i] = 0; m_sel[i] = 4'hF;
      end
      m_rd[i] = mem_m[i][m_addr[i][9:2]];
      if (m_we[i])
        for (int b = 0; b < 4; b++)
          if (m_sel[i][b]) mem_m[i][m_addr[i][9:2]][8*b +: 8] = m_wdata[i][8*b +: 8];
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
      cyc++;
    end
  end

  task automatic compare(int i);
    bit en_e, ifr_e, memr_e;
    en_e   = m_busy[i] && (cyc == m_start[i] + 1);
    ifr_e  = m_busy[i] && (cyc == m_start[i] + lat(i) + 2) && !m_own_mem[i];
    memr_e = m_busy[i] && (cyc == m_start[i] + lat(i) + 2) && m_own_mem[i];
    chk($sformatf("ram_en[%0d]", i), 32'(ram_en_o[i]), 32'(en_e));
    chk($sformatf("ram_we[%0d]", i), 32'(ram_we_o[i]), 32'(en_e && m_we[i]));
    chk($sformatf("ram_addr[%0d]", i), ram_addr_o[i], m_addr[i]);
    chk($sformatf("ram_sel[%0d]", i), 32'(ram_sel_o[i]), 32'(m_sel[i]));
    chk($sformatf("ram_wdata[%0d]", i), ram_wdata_o[i], m_wdata[i]);
    chk($sformatf("if_ready[%0d]", i), 32'(if_ready_o[i]), 32'(ifr_e));
    chk($sformatf("mem_ready[%0d]", i), 32'(mem_ready_o[i]), 32'(memr_e));
    chk($sformatf("if_rdata[%0d]", i), if_rdata_o[i], m_if_rd[i]);
    if (m_mem_known[i]) chk($sformatf("mem_rdata[%0d]", i), mem_rdata_o[i], m_mem_rd[i]);
    chk($sformatf("stall_req[%0d]", i), 32'(stall_o[i]),
        32'((if_req && !ifr_e) || (mem_req && !memr_e)));
  endtask

  bit          rec;
  logic [31:0] grants [$];

  initial begin
    rec = 0;
    forever begin
      @(negedge clk);
      if (cyc > 0) for (int i = 0; i < 2; i++) compare(i);
      if (rec && ram_en_o[0]) grants.push_back(ram_addr_o[0]);
    end
  end

  // RAM model: read data appears LATENCY edges after sampled ram_en; junk before.
  logic        s_en [2], s_we [2];
  logic [3:0]  s_sel [2];
  logic [31:0] s_addr [2], s_wdata [2], pend [2], rd_v;
  int          due [2], edge_n;

  initial begin
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      ram_rdata_i[i] = '0; due[i] = -1; pend[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s_en[i] = ram_en_o[i]; s_we[i] = ram_we_o[i]; s_sel[i] = ram_sel_o[i];
        s_addr[i] = ram_addr_o[i]; s_wdata[i] = ram_wdata_o[i];
      end
      @(posedge clk);
      #1;
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        if (due[i] == edge_n) ram_rdata_i[i] = pend[i];
        if (s_en[i] === 1'b1) begin
          rd_v = ram_mem[i][s_addr[i][9:2]];
          if (s_we[i] === 1'b1)
            for (int b = 0; b < 4; b++)
              if (s_sel[i][b]) ram_mem[i][s_addr[i][9:2]][8*b +: 8] = s_wdata[i][8*b +: 8];
          if (lat(i) == 1) ram_rdata_i[i] = rd_v;
          else begin
            ram_rdata_i[i] = 32'hBAD0_0000 | i;
            pend[i] = rd_v;
            due[i] = edge_n + lat(i) - 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic [31:0] exp_g [3];

  initial begin
    tests = 0; fails = 0;
    rst = 1; if_req = 0; mem_req = 0; mem_we = 0; mem_sel = 4'h0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 256; w++) begin
        mem_m[i][w]   = 32'hA500_0000 | w;
        ram_mem[i][w] = 32'hA500_0000 | w;
      end
    for (int i = 0; i < 2; i++) begin
      mem_m[i][4] = 32'h2408_0005; ram_mem[i][4] = 32'h2408_0005;
      mem_m[i][64] = 32'h0;        ram_mem[i][64] = 32'h0;
    end
`ifdef ARB_FAIR_EN
    exp_g[0] = 32'h80; exp_g[1] = 32'h40; exp_g[2] = 32'h80;
`else
    exp_g[0] = 32'h80; exp_g[1] = 32'h80; exp_g[2] = 32'h80;
`endif

    repeat (3) step();
    neg();
    chk("lit_rst_ram_en", 32'(ram_en_o[0]), 32'h0);
    chk("lit_rst_ram_sel", 32'(ram_sel_o[0]), 32'h0);
    chk("lit_rst_if_rdata", if_rdata_o[0], 32'h0);
    chk("lit_rst_stall", 32'(stall_o[0]), 32'h0);
    step(); rst = 0;
    repeat (2) step();

    // Fetch from 0x10; address changes to 0x20 mid-WAIT.
    step(); if_req = 1; if_addr = 32'h10;
    neg(); chk("lit_fetch_stall", 32'(stall_o[0]), 32'h1);
    step(); neg();
    chk("lit_fetch_en", 32'(ram_en_o[0]), 32'h1);
    chk("lit_fetch_addr", ram_addr_o[0], 32'h10);
    chk("lit_fetch_we", 32'(ram_we_o[0]), 32'h0);
    chk("lit_fetch_sel", 32'(ram_sel_o[0]), 32'hF);
    chk("lit_lat4_en", 32'(ram_en_o[1]), 32'h1);
    step(); if_addr = 32'h20;
    neg(); chk("lit_late_addr", ram_addr_o[0], 32'h10);
    step(); neg();
    chk("lit_fetch_ready", 32'(if_ready_o[0]), 32'h1);
    chk("lit_fetch_rdata", if_rdata_o[0], 32'h2408_0005);
    step(); step(); neg();
    chk("lit_refetch_addr", ram_addr_o[0], 32'h20);
    chk("lit_lat4_late_addr", ram_addr_o[1], 32'h10);
    chk("lit_lat4_noready", 32'(if_ready_o[1]), 32'h0);
    step(); neg();
    chk("lit_lat4_ready", 32'(if_ready_o[1]), 32'h1);
    chk("lit_lat4_rdata", if_rdata_o[1], 32'h2408_0005);
    step(); neg(); chk("lit_lat4_idle", 32'(ram_en_o[1]), 32'h0);
    step(); neg();
    chk("lit_lat4_regrant", 32'(ram_en_o[1]), 32'h1);
    step(); if_req = 0;
    repeat (14) step();

    // Store then load back the half-word.
    step(); mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    step(); neg();
    chk("lit_st_en", 32'(ram_en_o[0]), 32'h1);
    chk("lit_st_we", 32'(ram_we_o[0]), 32'h1);
    chk("lit_st_sel", 32'(ram_sel_o[0]), 32'h3);
    chk("lit_st_wdata", ram_wdata_o[0], 32'hDEAD_BEEF);
    step(); neg(); chk("lit_st_en_single", 32'(ram_en_o[0]), 32'h0);
    step(); neg(); chk("lit_st_ready", 32'(mem_ready_o[0]), 32'h1);
    step(); mem_req = 0; mem_we = 0;
    repeat (10) step();
    step(); mem_req = 1; mem_sel = 4'hF; mem_addr = 32'h100;
    repeat (3) step();
    neg();
    chk("lit_ld_ready", 32'(mem_ready_o[0]), 32'h1);
    chk("lit_ld_rdata", mem_rdata_o[0], 32'h0000_BEEF);
    step(); mem_req = 0;
    repeat (10) step();

    // Contention: both held for three LATENCY=1 accesses.
    step(); rec = 1; if_req = 1; mem_req = 1; if_addr = 32'h40; mem_addr = 32'h80;
    repeat (10) step();
    step(); if_req = 0; mem_req = 0;
    neg(); rec = 0;
    chk("grant_count", grants.size(), 3);
    for (int j = 0; j < 3; j++)
      if (j < grants.size()) chk($sformatf("grant%0d", j), grants[j], exp_g[j]);
    repeat (14) step();

    // Reset for 3 cycles while both instances sit in WAIT.
    step(); if_req = 1; if_addr = 32'h10;
    step();
    step(); rst = 1;
    neg();
    step(); neg();
    chk("lit_abort_ready0", 32'(if_ready_o[0]), 32'h0);
    chk("lit_abort_en1", 32'(ram_en_o[1]), 32'h0);
    chk("lit_abort_addr1", ram_addr_o[1], 32'h0);
    chk("lit_abort_rdata0", if_rdata_o[0], 32'h0);
    chk("lit_abort_stall", 32'(stall_o[1]), 32'h1);
    step();
    step(); rst = 0; if_req = 0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory controller that shares one synchronous RAM between the IF stage (instruction fetch) and the MEM stage (loads/stores). It arbitrates the two requesters and sequences each access through a fixed-latency RAM. It returns registered read data with a one-cycle ready pulse, and raises a stall request to pipeline control while any requester is waiting. It sits between the IF/MEM stages and the unified instruction/data RAM.

## Interface
- LATENCY, 1, RAM cycles from sampled ram_en to valid ram_rdata; legal range ≥1.
- ADDR_W, 32, address width; matches `ADDR_BUS`.
- DATA_W, 32, data width; matches `DATA_BUS`.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset (`RST_ENABLE` = 1).
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse.
- mem_req  in  1  data request; level, held until mem_ready.
- mem_we  in  1  1 = store.
- mem_sel  in  4  byte enables.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM chip enable (`CHIP_ENABLE`).
- ram_we  out  1  RAM write enable.
- ram_sel  out  4  RAM byte enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- stall_req  out  1  combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready).

## Operation
- FSM states:
  - IDLE: samples requests. On any request, grants one, latches its address, we, sel and wdata into ram_* regs, records the owner, and goes to ACCESS.
  - ACCESS: ram_en=1 for exactly one cycle, then WAIT.
  - WAIT: counter loaded with LATENCY-1 counts to 0, so WAIT lasts LATENCY cycles. On the last WAIT edge, ram_rdata is captured into the owner's rdata register and the owner's ready is set; go to RESP.
  - RESP: owner's ready=1 for one cycle, then IDLE. No grant is made in RESP.
- Grant rule: when both request in IDLE, MEM wins (strict priority unless ARB_FAIR_EN is set).
- IF accesses drive ram_we=0 and ram_sel=4'hF.
- Stores run the full sequence. The owner's rdata captures ram_rdata anyway; its value is don't-care for stores.
- Non-owner rdata registers hold their last value.
- Address and data are latched at the grant edge. Requester changes after grant are ignored.
- A req dropped before its ready is a protocol violation. The access still completes and ready still pulses.
- ram_en/ram_we are 0 in every state other than ACCESS. ram_addr, ram_sel and ram_wdata hold their values.

## Timing
- Reset values: state IDLE; ram_en, ram_we, if_ready and mem_ready = 0; ram_sel = 0; ram_addr, ram_wdata, if_rdata and mem_rdata = `ZERO_WORD`; counter 0; fairness flag 0.
- Latency: req high in IDLE cycle c → ram_en in c+1 → ready in c+LATENCY+2 → IDLE in c+LATENCY+3, where the next grant may occur.
- Back-to-back throughput is one access per LATENCY+3 cycles.
- rst asserted in any state: next cycle is IDLE with reset values. An in-flight access is aborted, no ready pulse is produced, and ram_en is low.
- Simultaneous requests in IDLE: exactly one grant. The loser keeps stall_req high and is granted at the next IDLE.

## Configuration
- ARB_FAIR_EN defined:
  - A fairness flag is set when MEM is granted while if_req is also high.
  - At the next IDLE with both requesting, IF wins and the flag clears. Contention therefore alternates MEM, IF, MEM, IF…
- ARB_FAIR_EN undefined:
  - Strict MEM priority; IF can starve under continuous MEM traffic.
  - No fairness flag register exists.

## Structure
- Shared global definitions: `RST_ENABLE`, `CHIP_ENABLE`/`CHIP_DISABLE`, `ZERO_WORD`, `ADDR_BUS`, `DATA_BUS`.
- State encodings ARB_IDLE, ARB_ACCESS, ARB_WAIT and ARB_RESP, plus owner encodings OWN_IF and OWN_MEM, go in the shared define file.
- One sub-module, arb_grant: a combinational winner select from if_req, mem_req and the fairness flag. It contains the ARB_FAIR_EN variant.

## Test plan
- Reset: hold rst 3 cycles mid-WAIT → next cycle IDLE, all outputs 0, no ready pulse; stall_req follows its formula.
- Fetch, LATENCY=1, if_addr=0x0000_0010, ram_rdata=0x2408_0005 → ram_en in cycle 1 with ram_addr 0x10, ram_we 0, ram_sel 4'hF; if_ready and if_rdata=0x2408_0005 in cycle 3.
- Store: mem_we=1, mem_sel=4'b0011, mem_addr=0x0000_0100, mem_wdata=0xDEAD_BEEF → single-cycle ram_en with identical ram_* values; mem_ready in cycle 3.
- Contention, no ARB_FAIR_EN: both held for 3 accesses → grants MEM, MEM, MEM while IF stalls. With ARB_FAIR_EN → grants MEM, IF, MEM.
- LATENCY=4: fetch → ram_en in cycle 1, if_ready in cycle 6, next grant in cycle 7.
- Late requester change: change if_addr to 0x20 during WAIT → ram_addr stays at the originally latched 0x10.
